nanov_serial_core: RTL and testbench

- Bit-serial RV32E integer core. Executes one instruction over one or more 32-clock passes, one bit per clock, LSB first.
- Instruction fetch, PC and memory live outside the block. The core holds the 16-entry register file and the serial ALU.
- It reports a parallel result/address/store-data word and a branch-taken flag.

---
 rtl/nanov_serial_core.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_nanov_serial_core.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_serial_core.sv
`default_nettype none
// ============================================================================
//  Module   : nanov_serial_core
//  Purpose  : Bit-serial RV32E integer datapath. One instruction executes over
//             one or more 32-clock passes, one operand bit per clock, LSB
//             first. Holds the 16 x 32 register file and the serial ALU;
//             fetch, PC and memory live outside.
//  Ports    : clk      - clock, all state updates on the rising edge
//             rstn     - synchronous reset, active HIGH despite the name
//             instr    - current instruction, stable for all its passes
//             cycle    - pass index within the instruction (0 = first)
//             counter  - bit index of the current clock, 0..31
//             data_in  - serial load data, bit `counter` of the loaded word
//             data_out - parallel result / address / store-data word
//             branch   - registered branch-taken flag
//  Revision : 1.0 - initial release
// ============================================================================
module nanov_serial_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr,
    input  logic [2:0]  cycle,
    input  logic [4:0]  counter,
    input  logic        data_in,
    output logic [31:0] data_out,
    output logic        branch
);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] c_FN_ADD = 2'd0;
    localparam logic [1:0] c_FN_XOR = 2'd1;
    localparam logic [1:0] c_FN_OR  = 2'd2;
    localparam logic [1:0] c_FN_AND = 2'd3;

    // Instruction class: selects how many passes run and what each produces.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_SLT    = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_LUI    = 3'd6
    } cls_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_regs [16];
    logic [31:0] r_data_out;
    logic        r_carry;
    logic        r_neq;
    logic        r_lt;
    logic        r_branch;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic [3:0]  w_rd;
    cls_t        w_cls;
    logic        w_use_imm;
    logic        w_sub;
    logic        w_unsigned;
    logic [1:0]  w_fn;
    logic [31:0] w_imm;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    // Register fields use only their low four bits: RV32E has 16 registers.
    assign w_rs1    = instr[18:15];
    assign w_rs2    = instr[23:20];
    assign w_rd     = instr[10:7];

    always_comb begin
        w_cls      = CLS_NONE;
        w_use_imm  = 1'b0;
        w_sub      = 1'b0;
        w_unsigned = 1'b0;
        w_fn       = c_FN_ADD;
        w_imm      = {{20{instr[31]}}, instr[31:20]};
        case (w_opcode)
            c_OPC_OP_IMM, c_OPC_OP: begin
                w_use_imm = (w_opcode == c_OPC_OP_IMM);
                case (w_f3)
                    3'b000: begin
                        w_cls = CLS_ALU;
                        // funct7[5] selects SUB only for the register form.
                        w_sub = (w_opcode == c_OPC_OP) && instr[30];
                    end
                    3'b010: begin
                        w_cls = CLS_SLT;
                        w_sub = 1'b1;
                    end
                    3'b011: begin
                        w_cls      = CLS_SLT;
                        w_sub      = 1'b1;
                        w_unsigned = 1'b1;
                    end
                    3'b100: begin
                        w_cls = CLS_ALU;
                        w_fn  = c_FN_XOR;
                    end
                    3'b110: begin
                        w_cls = CLS_ALU;
                        w_fn  = c_FN_OR;
                    end
                    3'b111: begin
                        w_cls = CLS_ALU;
                        w_fn  = c_FN_AND;
                    end
                    default: w_cls = CLS_NONE;
                endcase
            end
            c_OPC_LOAD: begin
                w_cls     = CLS_LOAD;
                w_use_imm = 1'b1;
            end
            c_OPC_STORE: begin
                w_cls     = CLS_STORE;
                w_use_imm = 1'b1;
                w_imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            c_OPC_BRANCH: begin
                // funct3 = 010/011 is not a branch encoding.
                w_cls      = (w_f3[2:1] == 2'b01) ? CLS_NONE : CLS_BRANCH;
                w_sub      = 1'b1;
                w_unsigned = w_f3[1];
                w_imm      = {{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            end
            c_OPC_LUI: begin
                w_cls = CLS_LUI;
                w_imm = {instr[31:12], 12'b0};
            end
            default: w_cls = CLS_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serial ALU
    // ------------------------------------------------------------------
    logic w_a;
    logic w_b;
    logic w_imm_bit;
    logic w_op2;
    logic w_op2x;
    logic w_cin;
    logic w_sum;
    logic w_cout;
    logic w_alu;
    logic w_lt;
    logic w_neq;
    logic w_cond;

    // The LSB of every register is the current operand bit; x0 reads 0.
    assign w_a       = (w_rs1 == 4'd0) ? 1'b0 : r_regs[w_rs1][0];
    assign w_b       = (w_rs2 == 4'd0) ? 1'b0 : r_regs[w_rs2][0];
    assign w_imm_bit = w_imm[counter];
    assign w_op2     = w_use_imm ? w_imm_bit : w_b;
    assign w_op2x    = w_op2 ^ w_sub;
    // Bit 0 takes the subtract carry-in instead of the previous carry.
    assign w_cin     = (counter == 5'd0) ? w_sub : r_carry;
    assign w_sum     = w_a ^ w_op2x ^ w_cin;
    assign w_cout    = (w_a & w_op2x) | (w_a & w_cin) | (w_op2x & w_cin);

    always_comb begin
        w_alu = w_sum;
        case (w_fn)
            c_FN_XOR: w_alu = w_a ^ w_op2;
            c_FN_OR:  w_alu = w_a | w_op2;
            c_FN_AND: w_alu = w_a & w_op2;
            default:  w_alu = w_sum;
        endcase
    end

    // Meaningful only on the MSB clock. Signed: differing signs decide
    // directly, otherwise the sign of the difference (no overflow possible).
    // Unsigned: a borrow out of rs1 - op2 means rs1 < op2.
    assign w_lt  = w_unsigned ? ~w_cout : ((w_a != w_op2) ? w_a : w_sum);
    assign w_neq = ((counter == 5'd0) ? 1'b0 : r_neq) | (w_a ^ w_op2);

    always_comb begin
        w_cond = 1'b0;
        case (w_f3)
            3'b000:  w_cond = ~w_neq;
            3'b001:  w_cond = w_neq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_lt;
            3'b111:  w_cond = ~w_lt;
            default: w_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pass control
    // ------------------------------------------------------------------
    logic w_shift;
    logic w_res;
    logic w_wr;
    logic w_wr_en;
    logic w_lt_upd;
    logic w_br_upd;
    logic w_br_val;
    logic w_first;

    assign w_first = (cycle == 3'd0);

    always_comb begin
        w_shift  = 1'b0;
        w_res    = 1'b0;
        w_wr     = 1'b0;
        w_lt_upd = 1'b0;
        w_br_val = 1'b0;
        case (w_cls)
            CLS_ALU: begin
                w_shift = w_first;
                w_res   = w_alu;
                w_wr    = w_first;
            end
            CLS_LUI: begin
                w_shift = w_first;
                w_res   = w_imm_bit;
                w_wr    = w_first;
            end
            CLS_SLT: begin
                if (w_first) begin
                    w_shift  = 1'b1;
                    w_res    = w_sum;
                    w_lt_upd = (counter == 5'd31);
                end else if (cycle == 3'd1) begin
                    // Only bit 0 of the result can be set.
                    w_shift = 1'b1;
                    w_res   = (counter == 5'd0) & r_lt;
                    w_wr    = 1'b1;
                end
            end
            CLS_LOAD: begin
                if (w_first) begin
                    w_shift = 1'b1;
                    w_res   = w_sum;
                end else if (cycle == 3'd1) begin
                    w_shift = 1'b1;
                    w_res   = data_in;
                    w_wr    = 1'b1;
                end
            end
            CLS_STORE: begin
                if (w_first) begin
                    w_shift = 1'b1;
                    w_res   = w_sum;
                end else if (cycle == 3'd1) begin
                    w_shift = 1'b1;
                    w_res   = w_b;
                end
            end
            CLS_BRANCH: begin
                w_br_val = w_cond;
            end
            default: begin
                // Unsupported: shift zeros through data_out on the first pass.
                w_shift = w_first;
                w_res   = 1'b0;
            end
        endcase
    end

    assign w_wr_en  = w_wr && (w_rd != 4'd0);
    // Every instruction's first pass ends by refreshing the branch flag;
    // non-branches simply refresh it to 0.
    assign w_br_upd = w_first && (counter == 5'd31);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_data_out <= 32'd0;
            r_carry    <= 1'b0;
            r_neq      <= 1'b0;
            r_lt       <= 1'b0;
            r_branch   <= 1'b0;
        end else begin
            // All registers rotate right every clock so that after 32
            // clocks each is realigned; the destination takes the result
            // bit at its MSB instead of its own wrapped bit 0.
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= {(w_wr_en && (w_rd == 4'(i))) ? w_res : r_regs[i][0],
                              r_regs[i][31:1]};
            end
            if (w_shift) begin
                r_data_out <= {w_res, r_data_out[31:1]};
            end
            r_carry <= w_cout;
            r_neq   <= w_neq;
            if (w_lt_upd) begin
                r_lt <= w_lt;
            end
            if (w_br_upd) begin
                r_branch <= w_br_val;
            end
        end
    end

    assign data_out = r_data_out;
    assign branch   = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_nanov_serial_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nanov_serial_core
//  Purpose  : Directed self-checking bench for nanov_serial_core. Expected
//             words are queued as each instruction is issued and popped when
//             the pass completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nanov_serial_core;

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic        data_in;
    logic [31:0] data_out;
    logic        branch;

    int n_checks;
    int n_errors;

    typedef struct {
        string       tag;
        logic        is_br;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    nanov_serial_core u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .instr    (instr),
        .cycle    (cycle),
        .counter  (counter),
        .data_in  (data_in),
        .data_out (data_out),
        .branch   (branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Instruction encoders
    // ------------------------------------------------------------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus / scoreboard helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input string tag, input logic is_br, input logic [31:0] val);
        exp_t e;
        e.tag   = tag;
        e.is_br = is_br;
        e.val   = val;
        sb_q.push_back(e);
    endtask

    task automatic run_pass(input logic [31:0] ins, input logic [2:0] cyc,
                            input logic [31:0] din);
        instr = ins;
        cycle = cyc;
        for (int k = 0; k < 32; k++) begin
            counter = 5'(k);
            data_in = din[k];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_next();
        exp_t        e;
        logic [31:0] got;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed data_out %h, required a queued expectation",
                   data_out);
        end else begin
            e   = sb_q.pop_front();
            got = e.is_br ? {31'b0, branch} : data_out;
            assert (got === e.val) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
            end
        end
    endtask

    // Single-pass instruction whose data_out word is checked.
    task automatic exec1(input string tag, input logic [31:0] ins, input logic [31:0] val);
        push_exp(tag, 1'b0, val);
        run_pass(ins, 3'd0, 32'd0);
        check_next();
    endtask

    // Branch instruction whose taken flag is checked.
    task automatic exec_br(input string tag, input logic [31:0] ins, input logic val);
        push_exp(tag, 1'b1, {31'b0, val});
        run_pass(ins, 3'd0, 32'd0);
        check_next();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn     = 1'b1;
        instr    = 32'd0;
        cycle    = 3'd0;
        counter  = 5'd0;
        data_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;

        push_exp("reset_data_out", 1'b0, 32'd0);
        check_next();
        push_exp("reset_branch", 1'b1, 32'd0);
        check_next();

        // Basic ALU
        exec1("addi_x1", 32'h00500093, 32'd5);
        exec1("addi_x2_neg", enc_i(12'hFFD, 5'd1, 3'b000, 5'd2, 7'b0010011), 32'd2);
        exec1("add_x3", enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd7);
        exec1("sub_x4", enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4), 32'hFFFF_FFFD);
        exec1("xor_x10", enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10), 32'd7);
        exec1("or_x11", enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11), 32'd7);
        exec1("and_x12", enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd12), 32'd0);

        // SLT x5,x4,x1: -3 < 5 signed
        run_pass(enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd5), 3'd0, 32'd0);
        push_exp("slt_word", 1'b0, 32'd1);
        run_pass(enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd5), 3'd1, 32'd0);
        check_next();
        exec1("slt_readback", enc_i(12'd0, 5'd5, 3'b000, 5'd6, 7'b0010011), 32'd1);

        // SLTU x5,x4,x1: 0xFFFFFFFD < 5 unsigned is false
        run_pass(enc_r(7'h00, 5'd1, 5'd4, 3'b011, 5'd5), 3'd0, 32'd0);
        run_pass(enc_r(7'h00, 5'd1, 5'd4, 3'b011, 5'd5), 3'd1, 32'd0);
        exec1("sltu_readback", enc_i(12'd0, 5'd5, 3'b000, 5'd6, 7'b0010011), 32'd0);

        // SLTI x13,x4,-3: equal operands, not less
        push_exp("slti_equal", 1'b0, 32'd0);
        run_pass(enc_i(12'hFFD, 5'd4, 3'b010, 5'd13, 7'b0010011), 3'd0, 32'd0);
        run_pass(enc_i(12'hFFD, 5'd4, 3'b010, 5'd13, 7'b0010011), 3'd1, 32'd0);
        check_next();

        // SLTIU x13,x1,6: 5 < 6
        push_exp("sltiu_less", 1'b0, 32'd1);
        run_pass(enc_i(12'd6, 5'd1, 3'b011, 5'd13, 7'b0010011), 3'd0, 32'd0);
        run_pass(enc_i(12'd6, 5'd1, 3'b011, 5'd13, 7'b0010011), 3'd1, 32'd0);
        check_next();

        // Branches
        exec_br("beq_x1_x1", enc_b(13'd8, 5'd1, 5'd1, 3'b000), 1'b1);
        exec_br("bne_x1_x1", enc_b(13'd8, 5'd1, 5'd1, 3'b001), 1'b0);
        exec_br("blt_x4_x1", enc_b(13'd8, 5'd1, 5'd4, 3'b100), 1'b1);
        exec_br("bltu_x4_x1", enc_b(13'd8, 5'd1, 5'd4, 3'b110), 1'b0);
        exec_br("bge_x1_x4", enc_b(13'd8, 5'd4, 5'd1, 3'b101), 1'b1);

        // Non-branch clears the flag; x0 write discarded
        push_exp("addi_x0_word", 1'b0, 32'd1);
        push_exp("branch_cleared", 1'b1, 32'd0);
        run_pass(enc_i(12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011), 3'd0, 32'd0);
        check_next();
        check_next();
        exec1("add_x8_x0", enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd8), 32'd0);

        // LW x7,4(x1)
        push_exp("lw_addr", 1'b0, 32'd9);
        run_pass(enc_i(12'd4, 5'd1, 3'b010, 5'd7, 7'b0000011), 3'd0, 32'd0);
        check_next();
        run_pass(enc_i(12'd4, 5'd1, 3'b010, 5'd7, 7'b0000011), 3'd1, 32'hDEAD_BEEF);

        // SW x7,0(x1)
        push_exp("sw_addr", 1'b0, 32'd5);
        run_pass(enc_s(12'd0, 5'd7, 5'd1), 3'd0, 32'd0);
        check_next();
        push_exp("sw_data", 1'b0, 32'hDEAD_BEEF);
        run_pass(enc_s(12'd0, 5'd7, 5'd1), 3'd1, 32'd0);
        check_next();

        // LUI, then an extra pass beyond ADDI's count must neither shift nor write
        exec1("lui_x14", {20'h12345, 5'd14, 7'b0110111}, 32'h1234_5000);
        push_exp("extra_pass_hold", 1'b0, 32'h1234_5000);
        run_pass(enc_i(12'd0, 5'd1, 3'b000, 5'd14, 7'b0010011), 3'd1, 32'd0);
        check_next();
        exec1("x14_unchanged", enc_i(12'd0, 5'd14, 3'b000, 5'd15, 7'b0010011), 32'h1234_5000);

        // Reset in the middle of an instruction after setting branch
        exec_br("beq_before_reset", enc_b(13'd8, 5'd1, 5'd1, 3'b000), 1'b1);
        instr = enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011);
        cycle = 3'd0;
        for (int k = 0; k < 10; k++) begin
            counter = 5'(k);
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        push_exp("midreset_data_out", 1'b0, 32'd0);
        check_next();
        push_exp("midreset_branch", 1'b1, 32'd0);
        check_next();
        exec1("regs_cleared", enc_r(7'h00, 5'd3, 5'd1, 3'b000, 5'd9), 32'd0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
